// File: rtl/bus_terminal_fifo.sv
// bus_terminal_fifo
// Device-side terminal for one slot of the parallel bus. It has two FIFOs:
// - The TX FIFO holds device packets. It presents the head to the bus on
//   D_pop, with pndng, and the bus drains it with pop.
// - The RX FIFO captures bus pushes. The device drains it with a
//   valid/ready handshake.
// Every output is a register or a decode of registered state.

module bus_terminal_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int cnt_w   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tx_valid,
  input  logic [pckg_sz-1:0]           tx_data,
  output logic                         tx_ready,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  output logic                         rx_valid,
  output logic [pckg_sz-1:0]           rx_data,
  input  logic                         rx_ready,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic [$clog2(depth+1)-1:0]   rx_count,
  output logic [cnt_w-1:0]             rx_drop_cnt,
  output logic [1:0]                   err_flags
);

  localparam int PTR_W = $clog2(depth);
  localparam int OCC_W = $clog2(depth+1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(depth);

  logic [pckg_sz-1:0] tx_mem_r [depth];
  logic [pckg_sz-1:0] rx_mem_r [depth];
  logic [PTR_W-1:0]   tx_wr_ptr_r, tx_rd_ptr_r;
  logic [PTR_W-1:0]   rx_wr_ptr_r, rx_rd_ptr_r;
  logic [OCC_W-1:0]   tx_count_r, rx_count_r;
  logic [cnt_w-1:0]   rx_drop_cnt_r;
  logic [1:0]         err_flags_r;

  logic tx_ready_s, pndng_s, rx_valid_s;
  logic tx_wr_s, tx_rd_s, pop_err_s;
  logic rx_room_s, rx_wr_s, rx_rd_s, rx_drop_s;

  // Handshake strobes, all qualified by registered occupancy
  always_comb begin
    tx_ready_s = (tx_count_r != FULL_CNT);
    pndng_s    = (tx_count_r != {OCC_W{1'b0}});
    rx_valid_s = (rx_count_r != {OCC_W{1'b0}});
    tx_wr_s    = tx_valid && tx_ready_s;
    tx_rd_s    = pop && pndng_s;
    pop_err_s  = pop && !pndng_s;
    rx_rd_s    = rx_valid_s && rx_ready;
    // A full RX FIFO still takes a push when the device reads in the same cycle
    rx_room_s  = (rx_count_r != FULL_CNT) || rx_rd_s;
    rx_wr_s    = push && rx_room_s;
    rx_drop_s  = push && !rx_room_s;
  end

  // Output decode from registered state; heads read as zero when empty
  always_comb begin
    tx_ready    = tx_ready_s;
    pndng       = pndng_s;
    rx_valid    = rx_valid_s;
    tx_count    = tx_count_r;
    rx_count    = rx_count_r;
    rx_drop_cnt = rx_drop_cnt_r;
    err_flags   = err_flags_r;
    if (pndng_s) begin
      D_pop = tx_mem_r[tx_rd_ptr_r];
    end else begin
      D_pop = {pckg_sz{1'b0}};
    end
    if (rx_valid_s) begin
      rx_data = rx_mem_r[rx_rd_ptr_r];
    end else begin
      rx_data = {pckg_sz{1'b0}};
    end
  end

  // Storage arrays; contents need no reset because empty FIFOs mask the heads
  always_ff @(posedge clock) begin
    if (tx_wr_s) tx_mem_r[tx_wr_ptr_r] <= tx_data;
    if (rx_wr_s) rx_mem_r[rx_wr_ptr_r] <= D_push;
  end

  // TX pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wr_ptr_r <= {PTR_W{1'b0}};
      tx_rd_ptr_r <= {PTR_W{1'b0}};
      tx_count_r  <= {OCC_W{1'b0}};
    end else begin
      if (tx_wr_s) tx_wr_ptr_r <= tx_wr_ptr_r + 1'b1;
      if (tx_rd_s) tx_rd_ptr_r <= tx_rd_ptr_r + 1'b1;
      case ({tx_wr_s, tx_rd_s})
        2'b10:   tx_count_r <= tx_count_r + 1'b1;
        2'b01:   tx_count_r <= tx_count_r - 1'b1;
        default: tx_count_r <= tx_count_r;
      endcase
    end
  end

  // RX pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wr_ptr_r <= {PTR_W{1'b0}};
      rx_rd_ptr_r <= {PTR_W{1'b0}};
      rx_count_r  <= {OCC_W{1'b0}};
    end else begin
      if (rx_wr_s) rx_wr_ptr_r <= rx_wr_ptr_r + 1'b1;
      if (rx_rd_s) rx_rd_ptr_r <= rx_rd_ptr_r + 1'b1;
      case ({rx_wr_s, rx_rd_s})
        2'b10:   rx_count_r <= rx_count_r + 1'b1;
        2'b01:   rx_count_r <= rx_count_r - 1'b1;
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  // Saturating drop counter and sticky error flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_drop_cnt_r <= {cnt_w{1'b0}};
      err_flags_r   <= 2'b00;
    end else begin
      if (rx_drop_s && (rx_drop_cnt_r != {cnt_w{1'b1}})) begin
        rx_drop_cnt_r <= rx_drop_cnt_r + 1'b1;
      end
      if (pop_err_s) err_flags_r[0] <= 1'b1;
      if (rx_drop_s) err_flags_r[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Directed testbench for bus_terminal_fifo. Inputs change 1ns after the
// rising edge, and outputs are sampled at that same point.

module tb_bus_terminal_fifo;

  localparam int PW = 16;
  localparam int DP = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tx_valid = 1'b0;
  logic [PW-1:0] tx_data = 16'h0000;
  logic          tx_ready;
  logic          pndng;
  logic [PW-1:0] D_pop;
  logic          pop = 1'b0;
  logic          push = 1'b0;
  logic [PW-1:0] D_push = 16'h0000;
  logic          rx_valid;
  logic [PW-1:0] rx_data;
  logic          rx_ready = 1'b0;
  logic [3:0]    tx_count;
  logic [3:0]    rx_count;
  logic [CW-1:0] rx_drop_cnt;
  logic [1:0]    err_flags;

  int checks = 0;
  int errors = 0;

  bus_terminal_fifo #(.pckg_sz(PW), .depth(DP), .cnt_w(CW)) dut (
    .clock(clock), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .rx_drop_cnt(rx_drop_cnt), .err_flags(err_flags)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (pndng !== 1'b0) begin errors++; $display("FAIL reset_pndng: got %b want 0", pndng); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    checks++; if (D_pop !== 16'h0000) begin errors++; $display("FAIL reset_d_pop: got %h want 0000", D_pop); end
    checks++; if (rx_valid !== 1'b0 || rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx: got valid %b data %h want 0 0000", rx_valid, rx_data); end
    checks++; if (tx_count !== 4'd0 || rx_count !== 4'd0) begin errors++; $display("FAIL reset_counts: got %0d %0d want 0 0", tx_count, rx_count); end
    checks++; if (rx_drop_cnt !== 16'd0 || err_flags !== 2'b00) begin errors++; $display("FAIL reset_err: got drop %0d flags %b want 0 00", rx_drop_cnt, err_flags); end
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_tx_order();
    tx_valid = 1'b1; tx_data = 16'hA001;
    cyc();
    checks++; if (pndng !== 1'b1 || D_pop !== 16'hA001) begin errors++; $display("FAIL tx_first_write: got pndng %b D_pop %h want 1 a001", pndng, D_pop); end
    tx_data = 16'hA002;
    cyc();
    tx_valid = 1'b0;
    checks++; if (tx_count !== 4'd2 || D_pop !== 16'hA001) begin errors++; $display("FAIL tx_two_writes: got cnt %0d D_pop %h want 2 a001", tx_count, D_pop); end
    pop = 1'b1;
    cyc();
    checks++; if (pndng !== 1'b1 || D_pop !== 16'hA002) begin errors++; $display("FAIL tx_pop1: got pndng %b D_pop %h want 1 a002", pndng, D_pop); end
    cyc();
    pop = 1'b0;
    checks++; if (pndng !== 1'b0 || D_pop !== 16'h0000 || tx_count !== 4'd0) begin errors++; $display("FAIL tx_pop2: got pndng %b D_pop %h cnt %0d want 0 0000 0", pndng, D_pop, tx_count); end
  endtask

  task automatic test_back_to_back();
    tx_valid = 1'b1; tx_data = 16'hE001;
    cyc();
    tx_data = 16'hE002; pop = 1'b1;
    cyc();
    tx_valid = 1'b0;
    checks++; if (tx_count !== 4'd1 || D_pop !== 16'hE002 || pndng !== 1'b1) begin errors++; $display("FAIL b2b_write_pop: got cnt %0d D_pop %h pndng %b want 1 e002 1", tx_count, D_pop, pndng); end
    cyc();
    pop = 1'b0;
    checks++; if (tx_count !== 4'd0) begin errors++; $display("FAIL b2b_drain: got cnt %0d want 0", tx_count); end
  endtask

  task automatic test_tx_full();
    logic [PW-1:0] exp_q [8];
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1'b1; tx_data = 16'hC000 + 16'(i);
      cyc();
    end
    checks++; if (tx_ready !== 1'b0 || tx_count !== 4'd8) begin errors++; $display("FAIL tx_full: got ready %b cnt %0d want 0 8", tx_ready, tx_count); end
    // The write offered alongside the pop must be refused: no write-through when full
    tx_data = 16'hC0EE; pop = 1'b1;
    cyc();
    pop = 1'b0;
    checks++; if (tx_ready !== 1'b1 || tx_count !== 4'd7 || D_pop !== 16'hC001) begin errors++; $display("FAIL tx_full_pop: got ready %b cnt %0d D_pop %h want 1 7 c001", tx_ready, tx_count, D_pop); end
    tx_data = 16'hC0FF;
    cyc();
    tx_valid = 1'b0;
    checks++; if (tx_count !== 4'd8 || tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ninth: got cnt %0d ready %b want 8 0", tx_count, tx_ready); end
    for (int i = 0; i < 7; i++) exp_q[i] = 16'hC001 + 16'(i);
    exp_q[7] = 16'hC0FF;
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (D_pop !== exp_q[i]) begin errors++; $display("FAIL tx_drain_%0d: got %h want %h", i, D_pop, exp_q[i]); end
      cyc();
    end
    pop = 1'b0;
  endtask

  task automatic test_pop_empty();
    checks++; if (err_flags !== 2'b00) begin errors++; $display("FAIL pop_empty_pre: got flags %b want 00", err_flags); end
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    checks++; if (tx_count !== 4'd0 || pndng !== 1'b0 || D_pop !== 16'h0000) begin errors++; $display("FAIL pop_empty_state: got cnt %0d pndng %b D_pop %h want 0 0 0000", tx_count, pndng, D_pop); end
    cyc();
    cyc();
    checks++; if (err_flags !== 2'b01) begin errors++; $display("FAIL pop_empty_sticky: got flags %b want 01", err_flags); end
    // A write after the bad pop lands at slot head; pointers were untouched
    tx_valid = 1'b1; tx_data = 16'h5A5A;
    cyc();
    tx_valid = 1'b0; pop = 1'b1;
    checks++; if (D_pop !== 16'h5A5A || tx_count !== 4'd1) begin errors++; $display("FAIL pop_empty_ptr: got D_pop %h cnt %0d want 5a5a 1", D_pop, tx_count); end
    cyc();
    pop = 1'b0;
  endtask

  task automatic test_rx_overflow();
    rx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; D_push = 16'hB000 + 16'(i);
      cyc();
    end
    push = 1'b0;
    checks++; if (rx_count !== 4'd8 || rx_drop_cnt !== 16'd2) begin errors++; $display("FAIL rx_overflow_cnt: got cnt %0d drop %0d want 8 2", rx_count, rx_drop_cnt); end
    checks++; if (err_flags !== 2'b11) begin errors++; $display("FAIL rx_overflow_flags: got %b want 11", err_flags); end
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL rx_drain_%0d: got valid %b data %h want 1 %h", i, rx_valid, rx_data, 16'hB000 + 16'(i)); end
      cyc();
    end
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0 || rx_data !== 16'h0000 || rx_count !== 4'd0) begin errors++; $display("FAIL rx_empty: got valid %b data %h cnt %0d want 0 0000 0", rx_valid, rx_data, rx_count); end
  endtask

  task automatic test_rx_full_simul();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; D_push = 16'hB0D0 + 16'(i);
      cyc();
    end
    D_push = 16'hB0AA; rx_ready = 1'b1;
    cyc();
    push = 1'b0; rx_ready = 1'b0;
    checks++; if (rx_count !== 4'd8 || rx_drop_cnt !== 16'd2) begin errors++; $display("FAIL rx_simul_cnt: got cnt %0d drop %0d want 8 2", rx_count, rx_drop_cnt); end
    checks++; if (rx_data !== 16'hB0D1) begin errors++; $display("FAIL rx_simul_head: got %h want b0d1", rx_data); end
    rx_ready = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    rx_ready = 1'b0;
    checks++; if (rx_data !== 16'hB0AA || rx_count !== 4'd1) begin errors++; $display("FAIL rx_simul_tail: got %h cnt %0d want b0aa 1", rx_data, rx_count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = 16'hD000 + 16'(i);
      cyc();
    end
    tx_valid = 1'b0;
    checks++; if (tx_count !== 4'd3) begin errors++; $display("FAIL reset_mid_pre: got cnt %0d want 3", tx_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (pndng !== 1'b0 || tx_count !== 4'd0 || D_pop !== 16'h0000) begin errors++; $display("FAIL reset_mid_tx: got pndng %b cnt %0d D_pop %h want 0 0 0000", pndng, tx_count, D_pop); end
    checks++; if (rx_valid !== 1'b0 || rx_drop_cnt !== 16'd0 || err_flags !== 2'b00 || tx_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_rx: got valid %b drop %0d flags %b ready %b want 0 0 00 1", rx_valid, rx_drop_cnt, err_flags, tx_ready); end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_back_to_back();
    test_tx_full();
    test_pop_empty();
    test_rx_overflow();
    test_rx_full_simul();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
